// File: rtl/vga_pkg.sv
// Shared types for the scaled VGA timing generator: per-axis timing description,
// pixel colour struct, controller states and the standard 640x480@60 timing.
package vga_pkg;

    typedef struct packed {
        int active;
        int fp;
        int sync;
        int bp;
    } vga_timing_t;

    localparam int VGA_COLOR_W = 8;

    typedef struct packed {
        logic [VGA_COLOR_W-1:0] r;
        logic [VGA_COLOR_W-1:0] g;
        logic [VGA_COLOR_W-1:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } vga_state_t;

    localparam vga_timing_t VGA_640_H = '{active: 640, fp: 16, sync: 96, bp: 48};
    localparam vga_timing_t VGA_480_V = '{active: 480, fp: 10, sync: 2,  bp: 33};

    function automatic int vga_total(input vga_timing_t t);
        return t.active + t.fp + t.sync + t.bp;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: counts 0..total-1 on each step and decodes the active and
// sync regions (region order: active, front porch, sync, back porch).
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter vga_timing_t T     = VGA_640_H,
    parameter int          CNT_W = $clog2(vga_total(T))
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_step,
    output logic [CNT_W-1:0] o_count,
    output logic             o_wrap,
    output logic             o_active,
    output logic             o_sync
);

    localparam logic [CNT_W-1:0] LAST     = CNT_W'(vga_total(T) - 1);
    localparam logic [CNT_W-1:0] ACT_END  = CNT_W'(T.active);
    localparam logic [CNT_W-1:0] SYNC_BEG = CNT_W'(T.active + T.fp);
    localparam logic [CNT_W-1:0] SYNC_END = CNT_W'(T.active + T.fp + T.sync);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_step) begin
            r_count <= (r_count == LAST) ? '0 : r_count + 1'b1;
        end
    end

    assign o_count  = r_count;
    assign o_wrap   = (r_count == LAST);
    assign o_active = (r_count < ACT_END);
    assign o_sync   = (r_count >= SYNC_BEG) && (r_count < SYNC_END);

endmodule

// File: rtl/vga_scaled_timing_gen.sv
// VGA timing generator with run-time 1x/2x/4x pixel replication from a synchronous
// frame memory; all pins sit two clocks behind the h/v counters.
module vga_scaled_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE       = VGA_640_H.active,
    parameter int H_FP           = VGA_640_H.fp,
    parameter int H_SYNC         = VGA_640_H.sync,
    parameter int H_BP           = VGA_640_H.bp,
    parameter int V_ACTIVE       = VGA_480_V.active,
    parameter int V_FP           = VGA_480_V.fp,
    parameter int V_SYNC         = VGA_480_V.sync,
    parameter int V_BP           = VGA_480_V.bp,
    parameter bit HS_POL         = 1'b0,
    parameter bit VS_POL         = 1'b0,
    parameter int COLOR_W        = VGA_COLOR_W,
    parameter int ADDR_W         = 19,
    parameter int MAX_SCALE_LOG2 = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [1:0]           scale_log2,
    input  logic [15:0]          frames_req,
    output logic                 pix_rd,
    output logic [ADDR_W-1:0]    pix_addr,
    input  logic [3*COLOR_W-1:0] pix_data,
    output logic                 Hsync,
    output logic                 Vsync,
    output logic [COLOR_W-1:0]   R,
    output logic [COLOR_W-1:0]   G,
    output logic [COLOR_W-1:0]   B,
    output logic                 de,
    output logic                 frame_start,
    output logic                 DONE
);

    localparam vga_timing_t H_T = '{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP};
    localparam vga_timing_t V_T = '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP};
    localparam int H_W = $clog2(vga_total(H_T));
    localparam int V_W = $clog2(vga_total(V_T));
    localparam logic [1:0]        MAX_S   = 2'(MAX_SCALE_LOG2);
    localparam logic [ADDR_W-1:0] H_ACT_A = ADDR_W'(H_ACTIVE);

    vga_state_t        r_state;
    logic [1:0]        r_scale;
    logic [15:0]       r_freq;
    logic [15:0]       r_frames;
    logic [ADDR_W-1:0] r_row_base;

    logic              w_run;
    logic              w_h_wrap;
    logic              w_h_act;
    logic              w_h_sync;
    logic              w_v_step;
    logic              w_v_wrap;
    logic              w_v_act;
    logic              w_v_sync;
    logic              w_frame_end;
    logic              w_pix_act;
    logic              w_row_end;
    logic [H_W-1:0]    w_h;
    logic [V_W-1:0]    w_v;
    logic [1:0]        w_scale_in;
    logic [V_W-1:0]    w_vmask;
    logic [ADDR_W-1:0] w_row_step;
    logic [ADDR_W-1:0] w_addr;

    logic              r_rd_p1;
    logic [ADDR_W-1:0] r_addr_p1;
    logic              r_act_p1;
    logic              r_hs_p1;
    logic              r_vs_p1;
    logic              r_fs_p1;
    logic              r_fin_p1;

    logic              r_de_p2;
    logic              r_hs_p2;
    logic              r_vs_p2;
    logic              r_fs_p2;
    logic              r_done_p2;

    vga_axis_counter #(.T(H_T), .CNT_W(H_W)) u_h_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_step   (w_run),
        .o_count  (w_h),
        .o_wrap   (w_h_wrap),
        .o_active (w_h_act),
        .o_sync   (w_h_sync)
    );

    vga_axis_counter #(.T(V_T), .CNT_W(V_W)) u_v_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_step   (w_v_step),
        .o_count  (w_v),
        .o_wrap   (w_v_wrap),
        .o_active (w_v_act),
        .o_sync   (w_v_sync)
    );

    assign w_run       = (r_state == ST_RUN);
    assign w_v_step    = w_run && w_h_wrap;
    assign w_frame_end = w_run && w_h_wrap && w_v_wrap;
    assign w_pix_act   = w_run && w_h_act && w_v_act;
    assign w_scale_in  = (scale_log2 > MAX_S) ? MAX_S : scale_log2;

    // Address = row_base + (h >> s); row_base steps by the scaled line width
    // once every 2^s lines, so no multiplier is needed.
    assign w_row_step  = H_ACT_A >> r_scale;
    assign w_vmask     = V_W'((32'd1 << r_scale) - 32'd1);
    assign w_row_end   = ((w_v & w_vmask) == w_vmask);
    assign w_addr      = r_row_base + (ADDR_W'(w_h) >> r_scale);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_scale    <= '0;
            r_freq     <= '0;
            r_frames   <= '0;
            r_row_base <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_scale    <= w_scale_in;
                    r_freq     <= frames_req;
                    r_row_base <= '0;
                    if (enable && !r_done_p2) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_h_wrap) begin
                        if (w_v_wrap) begin
                            r_row_base <= '0;
                        end else if (w_v_act && w_row_end) begin
                            r_row_base <= r_row_base + w_row_step;
                        end
                    end
                    if (w_frame_end) begin
                        r_frames <= r_frames + 16'd1;
                        if ((r_freq != 16'd0) && ((r_frames + 16'd1) == r_freq)) begin
                            r_state <= ST_FINISH;
                        end else if (enable) begin
                            r_scale <= w_scale_in;
                            r_freq  <= frames_req;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_FINISH: begin
                    r_state <= ST_FINISH;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // ---- stage p1: memory request and delayed timing flags ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_p1   <= 1'b0;
            r_addr_p1 <= '0;
            r_act_p1  <= 1'b0;
            r_hs_p1   <= 1'b0;
            r_vs_p1   <= 1'b0;
            r_fs_p1   <= 1'b0;
            r_fin_p1  <= 1'b0;
        end else begin
            r_rd_p1  <= w_pix_act;
            if (w_pix_act) begin
                r_addr_p1 <= w_addr;
            end
            r_act_p1 <= w_pix_act;
            r_hs_p1  <= w_run && w_h_sync;
            r_vs_p1  <= w_run && w_v_sync;
            r_fs_p1  <= w_run && (w_h == '0) && (w_v == '0);
            r_fin_p1 <= (r_state == ST_FINISH);
        end
    end

    // ---- stage p2: pins, aligned with the memory read data ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_de_p2   <= 1'b0;
            r_hs_p2   <= !HS_POL;
            r_vs_p2   <= !VS_POL;
            r_fs_p2   <= 1'b0;
            r_done_p2 <= 1'b0;
        end else begin
            r_de_p2   <= r_act_p1;
            r_hs_p2   <= r_hs_p1 ? HS_POL : !HS_POL;
            r_vs_p2   <= r_vs_p1 ? VS_POL : !VS_POL;
            r_fs_p2   <= r_fs_p1;
            r_done_p2 <= r_done_p2 | r_fin_p1;
        end
    end

    // The memory's output register already provides the stage-2 flop for colour;
    // gating it with de keeps blanking black without adding a third clock.
    assign {R, G, B}   = r_de_p2 ? pix_data : '0;
    assign pix_rd      = r_rd_p1;
    assign pix_addr    = r_addr_p1;
    assign de          = r_de_p2;
    assign Hsync       = r_hs_p2;
    assign Vsync       = r_vs_p2;
    assign frame_start = r_fs_p2;
    assign DONE        = r_done_p2;

endmodule

// File: tb/tb_vga_scaled_timing_gen.sv
// Directed bench for vga_scaled_timing_gen on a reduced 8x4 timing (H 8/2/2/2, V 4/1/1/1).
module tb_vga_scaled_timing_gen;

    localparam int CW = 8;
    localparam int AW = 19;
    localparam int HT = 14;
    localparam int VT = 7;
    localparam int FT = HT * VT;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic [1:0]    scale_log2;
    logic [15:0]   frames_req;
    logic          pix_rd;
    logic [AW-1:0] pix_addr;
    logic [3*CW-1:0] pix_data = '0;
    logic          Hsync;
    logic          Vsync;
    logic [CW-1:0] R;
    logic [CW-1:0] G;
    logic [CW-1:0] B;
    logic          de;
    logic          frame_start;
    logic          DONE;

    int n_checks = 0;
    int n_fail   = 0;
    bit mem_ones = 1'b0;
    logic [7:0]    cap_b    [FT];
    logic          cap_rd   [FT];
    logic [AW-1:0] cap_addr [FT];

    vga_scaled_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0),
        .COLOR_W(CW), .ADDR_W(AW), .MAX_SCALE_LOG2(2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .scale_log2  (scale_log2),
        .frames_req  (frames_req),
        .pix_rd      (pix_rd),
        .pix_addr    (pix_addr),
        .pix_data    (pix_data),
        .Hsync       (Hsync),
        .Vsync       (Vsync),
        .R           (R),
        .G           (G),
        .B           (B),
        .de          (de),
        .frame_start (frame_start),
        .DONE        (DONE)
    );

    always #5 clk = ~clk;

    // Synchronous frame memory: data = address (or all ones), one clock after pix_rd.
    always @(posedge clk) begin
        if (pix_rd) pix_data <= mem_ones ? 24'hFFFFFF : 24'(pix_addr);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_vec(input int k, input int s, input bit ones);
        int h;
        int v;
        int addr;
        bit act;
        logic [23:0] rgb;
        h    = k % HT;
        v    = k / HT;
        act  = (h < 8) && (v < 4);
        addr = (v >> s) * (8 >> s) + (h >> s);
        rgb  = !act ? 24'h0 : (ones ? 24'hFFFFFF : 24'(addr));
        return {3'b000, 1'(k == 0), 1'(act), 1'(!(h == 10 || h == 11)), 1'(v != 5), 1'b0, rgb};
    endfunction

    function automatic logic [31:0] obs_vec();
        return {3'b000, frame_start, de, Hsync, Vsync, DONE, R, G, B};
    endfunction

    task automatic wait_fs(output int n);
        n = 0;
        while (!frame_start && n < 400) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Checks one full frame of pins starting at the frame_start pulse.
    // act: 1 = set scale_log2 to act_val at pixel act_k, 2 = drop enable at act_k.
    task automatic run_frame(input string tag, input int s, input int act_k,
                             input int act, input logic [1:0] act_val);
        int n;
        int nde;
        wait_fs(n);
        if (!frame_start) begin
            check({tag, "_fs_timeout"}, 32'd0, 32'd1);
            return;
        end
        nde = 0;
        for (int k = 0; k < FT; k++) begin
            if (k == act_k) begin
                if (act == 1) scale_log2 = act_val;
                else if (act == 2) enable = 1'b0;
            end
            check(tag, obs_vec(), exp_vec(k, s, mem_ones));
            cap_b[k]    = B;
            cap_rd[k]   = pix_rd;
            cap_addr[k] = pix_addr;
            if (de) nde++;
            @(negedge clk);
        end
        check({tag, "_de_count"}, nde, 32'd32);
    endtask

    task automatic do_reset();
        enable = 1'b0;
        rst_n  = 1'b0;
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
    endtask

    initial begin
        int n;
        int nrd;
        int nfs;
        int nde;
        rst_n      = 1'b0;
        enable     = 1'b0;
        scale_log2 = 2'd0;
        frames_req = 16'd0;
        repeat (3) @(negedge clk);

        check("rst_hsync", 32'(Hsync), 32'd1);
        check("rst_vsync", 32'(Vsync), 32'd1);
        check("rst_de", 32'(de), 32'd0);
        check("rst_rgb", {8'h0, R, G, B}, 32'd0);
        check("rst_pix_rd", 32'(pix_rd), 32'd0);
        check("rst_pix_addr", 32'(pix_addr), 32'd0);
        check("rst_fs_done", {frame_start, DONE}, 32'd0);

        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_no_rd", 32'(pix_rd), 32'd0);

        // single frame then DONE two clocks after the counters finish
        frames_req = 16'd1;
        enable     = 1'b1;
        run_frame("t1_frame", 0, -1, 0, 2'd0);
        check("t1_done_rise", 32'(DONE), 32'd1);
        check("t1_no_fs", 32'(frame_start), 32'd0);
        repeat (30) @(negedge clk);
        check("t1_done_sticky", 32'(DONE), 32'd1);
        check("t1_finish_rd", 32'(pix_rd), 32'd0);
        check("t1_finish_sync", {Hsync, Vsync, de}, 32'b110);

        // two-frame request
        do_reset();
        frames_req = 16'd2;
        enable     = 1'b1;
        run_frame("t1b_f0", 0, -1, 0, 2'd0);
        run_frame("t1b_f1", 0, -1, 0, 2'd0);
        check("t1b_done", 32'(DONE), 32'd1);

        // 2x addressing
        do_reset();
        frames_req = 16'd0;
        scale_log2 = 2'd1;
        enable     = 1'b1;
        run_frame("t2_s1", 1, -1, 0, 2'd0);
        check("t2_addr_00", 32'(cap_b[0]), 32'd0);
        check("t2_addr_10", 32'(cap_b[1]), 32'd0);
        check("t2_addr_01", 32'(cap_b[14]), 32'd0);
        check("t2_addr_11", 32'(cap_b[15]), 32'd0);
        check("t2_addr_20", 32'(cap_b[2]), 32'd1);
        check("t2_addr_line2", 32'(cap_b[28]), 32'd4);
        check("t2_addr_last", 32'(cap_b[49]), 32'd7);
        check("t2_blank_rd", 32'(cap_rd[60]), 32'd0);
        check("t2_blank_hold", 32'(cap_addr[60]), 32'd7);

        // all-ones data: colour only while de
        do_reset();
        mem_ones   = 1'b1;
        scale_log2 = 2'd0;
        enable     = 1'b1;
        run_frame("t3_ones", 0, -1, 0, 2'd0);
        mem_ones   = 1'b0;

        // scale changes take effect at the next frame; 3 clamps to 2
        do_reset();
        scale_log2 = 2'd1;
        enable     = 1'b1;
        run_frame("t4_keep2x", 1, 40, 1, 2'd0);
        run_frame("t4_now1x", 0, 10, 1, 2'd3);
        run_frame("t4_clamp4x", 2, -1, 0, 2'd0);

        // reset mid-line
        do_reset();
        scale_log2 = 2'd0;
        enable     = 1'b1;
        wait_fs(n);
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("t5_rst_sync", {Hsync, Vsync}, 32'b11);
        check("t5_rst_de_rgb", {7'h0, de, R, G, B}, 32'd0);
        check("t5_rst_rd_addr", {12'h0, pix_rd, pix_addr}, 32'd0);
        check("t5_rst_fs_done", {frame_start, DONE}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_fs(n);
        check("t5_fs_latency", n, 32'd3);
        run_frame("t5_restart", 0, -1, 0, 2'd0);

        // enable dropped mid-frame, then re-enabled in free-run
        do_reset();
        frames_req = 16'd0;
        enable     = 1'b1;
        run_frame("t6_drop", 0, 30, 2, 2'd0);
        nrd = 0;
        nfs = 0;
        nde = 0;
        for (int i = 0; i < 40; i++) begin
            nrd += int'(pix_rd);
            nfs += int'(frame_start);
            nde += int'(de);
            @(negedge clk);
        end
        check("t6_idle_rd", nrd, 32'd0);
        check("t6_idle_fs", nfs, 32'd0);
        check("t6_idle_de", nde, 32'd0);
        enable = 1'b1;
        wait_fs(n);
        check("t6_reenable_lat", n, 32'd3);
        run_frame("t6_free0", 0, -1, 0, 2'd0);
        run_frame("t6_free1", 0, -1, 0, 2'd0);
        run_frame("t6_free2", 0, -1, 0, 2'd0);
        check("t6_no_done", 32'(DONE), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
